// File: rtl/frame_loopback_ctrl.sv
// ---------------------------------------------------------------------------
// frame_loopback_ctrl
//   Buffers one received PCD frame and, if it arrived clean, replays it byte
//   by byte to the tx block. Frames with rx errors, overflow, a partial byte
//   followed by more data, or no bytes are discarded with a frame_dropped
//   pulse.
//
// Optional build macro: FRAME_LOOPBACK_CTRL_STATS_EN
//   Adds saturating 16-bit counters frames_forwarded / frames_discarded.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   rx_soc / rx_eoc       start / end of received frame (1-cycle pulses)
//   rx_data[7:0]          received byte, LSB first
//   rx_data_bits[2:0]     valid bits in rx_data (0 = 8)
//   rx_data_valid         rx_data / rx_data_bits qualifier
//   rx_sequence_error,
//   rx_parity_error       rx error pulses
//   tx_data[7:0]          byte presented to tx (registered)
//   tx_data_bits[2:0]     valid bits in tx_data (0 = 8, registered)
//   tx_ready_to_send      tx_data holds a byte awaiting transmission
//   tx_req                tx consumed tx_data, wants the next one
//   busy                  state != IDLE
//   frame_dropped         1-cycle pulse when a frame is discarded
//   frames_forwarded,
//   frames_discarded      (stats build only) saturating frame counters
// ---------------------------------------------------------------------------
module frame_loopback_ctrl #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_soc,
    input  logic       rx_eoc,
    input  logic [7:0] rx_data,
    input  logic [2:0] rx_data_bits,
    input  logic       rx_data_valid,
    input  logic       rx_sequence_error,
    input  logic       rx_parity_error,
    output logic [7:0] tx_data,
    output logic [2:0] tx_data_bits,
    output logic       tx_ready_to_send,
    input  logic       tx_req,
    output logic       busy,
`ifdef FRAME_LOOPBACK_CTRL_STATS_EN
    output logic       frame_dropped,
    output logic [15:0] frames_forwarded,
    output logic [15:0] frames_discarded
`else
    output logic       frame_dropped
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;   // count must reach DEPTH itself

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_SEND} state_t;

    state_t         r_state,     w_state_nxt;
    logic [CW-1:0]  r_count,     w_count_nxt;   // also the write pointer
    logic [CW-1:0]  r_rptr,      w_rptr_nxt;    // index of byte on tx_data
    logic           r_err,       w_err_nxt;
    logic [2:0]     r_last_bits, w_last_nxt;
    logic [7:0]     r_tx_data,   w_txd_nxt;
    logic [2:0]     r_tx_bits,   w_txb_nxt;
    logic           r_tx_rdy,    w_rdy_nxt;
    logic           r_drop,      w_drop_nxt;
    logic           w_mem_we;
    logic           w_fwd;
    logic           w_rx_err;
    logic [CW-1:0]  w_rptr_inc;

    logic [7:0]     r_mem [DEPTH];

    assign w_rx_err   = rx_sequence_error | rx_parity_error;
    assign w_rptr_inc = r_rptr + CW'(1);

    assign tx_data          = r_tx_data;
    assign tx_data_bits     = r_tx_bits;
    assign tx_ready_to_send = r_tx_rdy;
    assign busy             = (r_state != S_IDLE);
    assign frame_dropped    = r_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_rptr      <= '0;
            r_err       <= 1'b0;
            r_last_bits <= 3'd0;
            r_tx_data   <= 8'd0;
            r_tx_bits   <= 3'd0;
            r_tx_rdy    <= 1'b0;
            r_drop      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_rptr      <= w_rptr_nxt;
            r_err       <= w_err_nxt;
            r_last_bits <= w_last_nxt;
            r_tx_data   <= w_txd_nxt;
            r_tx_bits   <= w_txb_nxt;
            r_tx_rdy    <= w_rdy_nxt;
            r_drop      <= w_drop_nxt;
        end
    end

    // Frame buffer: contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_count[AW-1:0]] <= rx_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_rptr_nxt  = r_rptr;
        w_err_nxt   = r_err;
        w_last_nxt  = r_last_bits;
        w_txd_nxt   = r_tx_data;
        w_txb_nxt   = r_tx_bits;
        w_rdy_nxt   = r_tx_rdy;
        w_drop_nxt  = 1'b0;
        w_mem_we    = 1'b0;
        w_fwd       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (rx_soc) begin
                    w_state_nxt = S_RECV;
                    w_count_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_last_nxt  = 3'd0;
                end
            end

            S_RECV: begin
                if (rx_soc) begin
                    // restart: drop what was collected, keep receiving
                    w_count_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_last_nxt  = 3'd0;
                end else if (rx_eoc) begin
                    // Error pulses coincident with eoc still spoil the frame;
                    // a data byte on the eoc cycle is not part of the frame.
                    if (r_err || w_rx_err || r_count == '0) begin
                        w_drop_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_fwd       = 1'b1;
                        w_state_nxt = S_SEND;
                        w_rdy_nxt   = 1'b1;
                        w_rptr_nxt  = '0;
                        w_txd_nxt   = r_mem[0];
                        w_txb_nxt   = (r_count == CW'(1)) ? r_last_bits : 3'd0;
                    end
                end else begin
                    if (w_rx_err) w_err_nxt = 1'b1;
                    if (rx_data_valid) begin
                        w_last_nxt = rx_data_bits;
                        // only the final byte of a frame may be partial
                        if (r_last_bits != 3'd0) w_err_nxt = 1'b1;
                        if (r_count == CW'(DEPTH)) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_mem_we    = 1'b1;
                            w_count_nxt = r_count + CW'(1);
                        end
                    end
                end
            end

            S_SEND: begin
                if (rx_soc) begin
                    // new frame pre-empts replay, even against a tx_req
                    w_state_nxt = S_RECV;
                    w_rdy_nxt   = 1'b0;
                    w_count_nxt = '0;
                    w_err_nxt   = 1'b0;
                    w_last_nxt  = 3'd0;
                end else if (tx_req) begin
                    if (w_rptr_inc < r_count) begin
                        w_rptr_nxt = w_rptr_inc;
                        w_txd_nxt  = r_mem[w_rptr_inc[AW-1:0]];
                        w_txb_nxt  = (w_rptr_inc + CW'(1) == r_count) ? r_last_bits : 3'd0;
                    end else begin
                        w_rdy_nxt   = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef FRAME_LOOPBACK_CTRL_STATS_EN
    logic [15:0] r_fwd_cnt, r_disc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_cnt  <= 16'd0;
            r_disc_cnt <= 16'd0;
        end else begin
            if (w_fwd && r_fwd_cnt != 16'hFFFF)       r_fwd_cnt  <= r_fwd_cnt + 16'd1;
            if (w_drop_nxt && r_disc_cnt != 16'hFFFF) r_disc_cnt <= r_disc_cnt + 16'd1;
        end
    end

    assign frames_forwarded = r_fwd_cnt;
    assign frames_discarded = r_disc_cnt;
`endif

endmodule

// File: tb/tb_frame_loopback_ctrl.sv
module tb_frame_loopback_ctrl;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_soc, rx_eoc, rx_data_valid;
    logic [7:0] rx_data;
    logic [2:0] rx_data_bits;
    logic       rx_sequence_error, rx_parity_error;
    logic [7:0] tx_data;
    logic [2:0] tx_data_bits;
    logic       tx_ready_to_send, tx_req, busy, frame_dropped;
`ifdef FRAME_LOOPBACK_CTRL_STATS_EN
    logic [15:0] frames_forwarded, frames_discarded;
`endif

    frame_loopback_ctrl #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .rx_soc            (rx_soc),
        .rx_eoc            (rx_eoc),
        .rx_data           (rx_data),
        .rx_data_bits      (rx_data_bits),
        .rx_data_valid     (rx_data_valid),
        .rx_sequence_error (rx_sequence_error),
        .rx_parity_error   (rx_parity_error),
        .tx_data           (tx_data),
        .tx_data_bits      (tx_data_bits),
        .tx_ready_to_send  (tx_ready_to_send),
        .tx_req            (tx_req),
        .busy              (busy),
`ifdef FRAME_LOOPBACK_CTRL_STATS_EN
        .frame_dropped     (frame_dropped),
        .frames_forwarded  (frames_forwarded),
        .frames_discarded  (frames_discarded)
`else
        .frame_dropped     (frame_dropped)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // reference frame currently being driven
    logic [7:0] fq_data[$];
    logic [2:0] fq_bits[$];
    int         err_at;          // byte index carrying an rx error, -1 = none
    int         exp_fwd = 0;
    int         exp_disc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: the spec's accept rule for a frame, from the byte list alone.
    function automatic bit model_drop();
        int n = fq_data.size();
        if (err_at >= 0) return 1'b1;
        if (n == 0 || n > DEPTH) return 1'b1;
        for (int i = 0; i < n - 1; i++)
            if (fq_bits[i] != 3'd0) return 1'b1;
        return 1'b0;
    endfunction

    // Drives optional soc, the bytes and eoc; checks the eoc outcome.
    task automatic send_frame(input bit with_soc);
        bit drop;
        if (with_soc) begin
            rx_soc = 1'b1; tick(); rx_soc = 1'b0;
        end
        for (int i = 0; i < fq_data.size(); i++) begin
            rx_data_valid = 1'b1;
            rx_data       = fq_data[i];
            rx_data_bits  = fq_bits[i];
            if (i == err_at) begin
                if ($urandom_range(0, 1) == 0) rx_parity_error = 1'b1;
                else                           rx_sequence_error = 1'b1;
            end
            tick();
            rx_data_valid = 1'b0; rx_parity_error = 1'b0; rx_sequence_error = 1'b0;
        end
        rx_eoc = 1'b1; tick(); rx_eoc = 1'b0;
        drop = model_drop();
        if (drop) exp_disc++; else exp_fwd++;
        chk("eoc_dropped", 32'(frame_dropped), 32'(drop));
        chk("eoc_ready",   32'(tx_ready_to_send), 32'(!drop));
        if (drop) begin
            tick();
            chk("drop_single_pulse", 32'(frame_dropped), 0);
            chk("drop_idle",         32'(busy), 0);
        end
    endtask

    // Walks the expected bytes through tx_req handshakes.
    task automatic drain();
        int n = fq_data.size();
        for (int i = 0; i < n; i++) begin
            chk("tx_ready", 32'(tx_ready_to_send), 1);
            chk("tx_data",  32'(tx_data), 32'(fq_data[i]));
            chk("tx_bits",  32'(tx_data_bits), (i == n - 1) ? 32'(fq_bits[i]) : 0);
            repeat ($urandom_range(0, 2)) begin
                tick();
                chk("tx_hold", 32'(tx_data), 32'(fq_data[i]));
            end
            tx_req = 1'b1; tick(); tx_req = 1'b0;
        end
        chk("end_ready", 32'(tx_ready_to_send), 0);
        chk("end_busy",  32'(busy), 0);
    endtask

    task automatic set_clean(input int n);
        fq_data.delete(); fq_bits.delete(); err_at = -1;
        for (int i = 0; i < n; i++) begin
            fq_data.push_back(8'($urandom));
            fq_bits.push_back(3'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; rx_soc = 0; rx_eoc = 0; rx_data = 0; rx_data_bits = 0;
        rx_data_valid = 0; rx_sequence_error = 0; rx_parity_error = 0; tx_req = 0;
        #3;
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_tx_bits", 32'(tx_data_bits), 0);
        chk("rst_ready",   32'(tx_ready_to_send), 0);
        chk("rst_busy",    32'(busy), 0);
        chk("rst_dropped", 32'(frame_dropped), 0);
        tick(); rst_n = 1'b1; tick();

        // three-byte frame with trailing partial byte
        fq_data = '{8'hA5, 8'h3C, 8'h0F}; fq_bits = '{3'd0, 3'd0, 3'd3}; err_at = -1;
        send_frame(1);
        drain();

        // parity error mid-frame
        fq_data = '{8'h11, 8'h22, 8'h33}; fq_bits = '{3'd0, 3'd0, 3'd0}; err_at = 1;
        send_frame(1);

        // overflow by one byte
        set_clean(DEPTH + 1);
        send_frame(1);

        // tx_req ignored in IDLE
        tx_req = 1'b1; tick(); tx_req = 1'b0;
        chk("idle_req_ready", 32'(tx_ready_to_send), 0);
        chk("idle_req_busy",  32'(busy), 0);

        // rx_soc beats a coincident tx_req in SEND
        set_clean(3);
        send_frame(1);
        rx_soc = 1'b1; tx_req = 1'b1; tick(); rx_soc = 1'b0; tx_req = 1'b0;
        chk("soc_win_ready",   32'(tx_ready_to_send), 0);
        chk("soc_win_dropped", 32'(frame_dropped), 0);
        chk("soc_win_busy",    32'(busy), 1);
        fq_data = '{8'h26}; fq_bits = '{3'd7}; err_at = -1;
        send_frame(0);
        drain();

        // reset during SEND after one byte consumed
        set_clean(4);
        send_frame(1);
        tx_req = 1'b1; tick(); tx_req = 1'b0;
        chk("mid_send_byte1", 32'(tx_data), 32'(fq_data[1]));
        rst_n = 1'b0; #1;
        chk("rst_send_data",  32'(tx_data), 0);
        chk("rst_send_bits",  32'(tx_data_bits), 0);
        chk("rst_send_ready", 32'(tx_ready_to_send), 0);
        chk("rst_send_busy",  32'(busy), 0);
        chk("rst_send_drop",  32'(frame_dropped), 0);
        exp_fwd = 0; exp_disc = 0;
        tick(); rst_n = 1'b1; tick();
        set_clean(4);
        send_frame(1);
        drain();

        // randomized frames against the model
        for (int f = 0; f < 40; f++) begin
            int n = $urandom_range(0, DEPTH + 4);
            set_clean(n);
            if (n > 0) begin
                fq_bits[n-1] = 3'($urandom);
                if ($urandom_range(0, 7) == 0) fq_bits[$urandom_range(0, n-1)] = 3'($urandom_range(1, 7));
                if ($urandom_range(0, 5) == 0) err_at = $urandom_range(0, n-1);
            end
            send_frame(1);
            if (!model_drop()) drain();
        end

`ifdef FRAME_LOOPBACK_CTRL_STATS_EN
        chk("stat_forwarded", 32'(frames_forwarded), 32'(exp_fwd));
        chk("stat_discarded", 32'(frames_discarded), 32'(exp_disc));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
